serial_frame_tx: RTL and testbench

- Serial frame transmitter: the sending end for our serial-bit sequence detectors.
- Accepts a parallel payload word over a valid/ready handshake and emits one bit per clock on a single line.
- Frame order: fixed sync pattern (default 11010), then payload MSB-first, then optional even-parity bit, then an idle gap.
- Drives detector-side benches and the serial link toward the detector FSMs.

---
 rtl/serial_frame_tx.sv | 135 +++++++++++++
 tb/tb_serial_frame_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter: sync word, MSB-first payload, optional even parity, idle gap
module serial_frame_tx #(
  parameter int                SYNC_W       = 5,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 5'b11010,
  parameter int                DATA_W       = 8,
  parameter bit                PARITY_EN    = 1'b1,
  parameter int                GAP_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              serial_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              frame_done
);
  localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] SYNC_TOP = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_TOP = CW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_TOP  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              par_q, par_n;
  logic              serial_n, bit_valid_n, frame_done_n;

  // Outputs are decoded from the next state so that they are registered yet
  // the first sync bit appears in the cycle right after the accepting edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    data_n  = data_q;
    par_n   = par_q;
    case (state)
      IDLE: begin
        if (data_valid) begin
          state_n = SYNC;
          cnt_n   = SYNC_TOP;
          data_n  = data_in;
          par_n   = 1'b0;
        end
      end
      SYNC: begin
        if (cnt == '0) begin
          state_n = DATA;
          cnt_n   = DATA_TOP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        par_n = par_q ^ data_q[cnt];
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (PARITY_EN) begin
          state_n = PAR;
        end else if (GAP_CYCLES > 0) begin
          state_n = GAP;
          gcnt_n  = GAP_TOP;
        end else begin
          state_n = IDLE;
        end
      end
      PAR: begin
        if (GAP_CYCLES > 0) begin
          state_n = GAP;
          gcnt_n  = GAP_TOP;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (gcnt == '0) state_n = IDLE;
        else            gcnt_n = gcnt - GW'(1);
      end
      default: state_n = IDLE;
    endcase

    serial_n     = 1'b0;
    bit_valid_n  = 1'b0;
    frame_done_n = 1'b0;
    case (state_n)
      SYNC: begin
        serial_n    = SYNC_PATTERN[cnt_n];
        bit_valid_n = 1'b1;
      end
      DATA: begin
        serial_n     = data_n[cnt_n];
        bit_valid_n  = 1'b1;
        frame_done_n = !PARITY_EN && (cnt_n == '0);
      end
      PAR: begin
        serial_n     = par_n;
        bit_valid_n  = 1'b1;
        frame_done_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      gcnt       <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      serial_out <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      data_ready <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      gcnt       <= gcnt_n;
      data_q     <= data_n;
      par_q      <= par_n;
      serial_out <= serial_n;
      bit_valid  <= bit_valid_n;
      busy       <= (state_n != IDLE);
      frame_done <= frame_done_n;
      data_ready <= (state_n == IDLE);
    end
  end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx (default, no-parity and zero-gap builds)
module tb_serial_frame_tx;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic [2:0] rdy, sout, bval, busy, fdone;

  always #5 clk = ~clk;

  // instance 0: defaults; instance 1: no parity; instance 2: no gap
  serial_frame_tx dut0 (.clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[0]), .serial_out(sout[0]), .bit_valid(bval[0]), .busy(busy[0]), .frame_done(fdone[0]));
  serial_frame_tx #(.PARITY_EN(1'b0)) dut1 (.clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[1]), .serial_out(sout[1]), .bit_valid(bval[1]), .busy(busy[1]), .frame_done(fdone[1]));
  serial_frame_tx #(.GAP_CYCLES(0)) dut2 (.clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[2]), .serial_out(sout[2]), .bit_valid(bval[2]), .busy(busy[2]), .frame_done(fdone[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc[3];
  int acc_gap[3];
  int acc_cnt[3];
  logic [4:0] sync_v = 5'b11010;
  logic [1:0] q0[$], q1[$], q2[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic q_push(int k, logic [1:0] e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(int k, output logic [1:0] e, output bit ok);
    ok = 1'b1;
    e  = 2'b00;
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // expected entries are {frame_done, serial bit}
  task automatic push_frame(int k, logic [7:0] d, bit par_en);
    for (int i = 4; i >= 0; i--) q_push(k, {1'b0, sync_v[i]});
    for (int i = 7; i >= 0; i--) q_push(k, {(!par_en && i == 0), d[i]});
    if (par_en) q_push(k, {1'b1, ^d});
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        if (data_valid && rdy[k]) begin
          push_frame(k, data_in, k != 1);
          acc_gap[k]  = cyc - last_acc[k];
          last_acc[k] = cyc;
          acc_cnt[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    bit ok;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        if (bval[k]) begin
          q_pop(k, e, ok);
          chk($sformatf("dut%0d_bit_expected", k), {31'd0, ok}, 32'd1);
          if (ok) chk($sformatf("dut%0d_bit@%0d", k, cyc), {30'd0, fdone[k], sout[k]}, {30'd0, e});
        end else begin
          chk($sformatf("dut%0d_idle_line@%0d", k, cyc), {30'd0, fdone[k], sout[k]}, 32'd0);
        end
      end
    end
  end

  always @(negedge reset) begin
    q0.delete();
    q1.delete();
    q2.delete();
  end

  task automatic wait_idle(string name);
    int n = 0;
    while (!(rdy == 3'b111 && q0.size() == 0 && q1.size() == 0 && q2.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, n < 100}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_pulse(logic [7:0] d);
    @(negedge clk);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [13:0] frame_bits;
    int base;
    frame_bits = '0;
    for (int k = 0; k < 3; k++) begin
      last_acc[k] = 0;
      acc_gap[k]  = 0;
      acc_cnt[k]  = 0;
    end
    reset      = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {29'd0, rdy}, 32'h7);
    chk("reset_outs", {17'd0, sout, bval, busy, fdone, 3'b000}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // A5 on the default build, cycle by cycle
    send_pulse(8'hA5);
    for (int i = 1; i <= 17; i++) begin
      if (i > 1) @(negedge clk);
      if (i <= 14) begin
        frame_bits = {frame_bits[12:0], sout[0]};
        chk($sformatf("a5_bit_valid_c%0d", i), {31'd0, bval[0]}, 32'd1);
        chk($sformatf("a5_frame_done_c%0d", i), {31'd0, fdone[0]}, {31'd0, i == 14});
      end else if (i <= 16) begin
        chk($sformatf("a5_gap_c%0d", i), {28'd0, busy[0], sout[0], bval[0], rdy[0]}, 32'h8);
      end else begin
        chk("a5_ready_c17", {30'd0, rdy[0], busy[0]}, 32'h2);
      end
    end
    chk("a5_frame", {18'd0, frame_bits}, {18'd0, 14'b11010_10100101_0});
    wait_idle("idle_after_a5");

    send_pulse(8'h01);
    wait_idle("idle_after_01");
    send_pulse(8'hFF);
    wait_idle("idle_after_ff");
    send_pulse(8'hD0);
    wait_idle("idle_after_d0");

    // held data_valid, payload changed mid-frame
    base = acc_cnt[0];
    @(negedge clk);
    data_in    = 8'h3C;
    data_valid = 1'b1;
    repeat (6) @(negedge clk);
    data_in = 8'hC3;
    for (int n = 0; n < 40 && acc_cnt[0] < base + 2; n++) @(negedge clk);
    data_valid = 1'b0;
    chk("held_second_accept", acc_cnt[0] - base, 32'd2);
    chk("spacing_default", acc_gap[0], 32'd17);
    chk("spacing_no_parity", acc_gap[1], 32'd16);
    chk("spacing_no_gap", acc_gap[2], 32'd15);
    wait_idle("idle_after_held");

    // reset during data bit 3 of the default build
    send_pulse(8'h5A);
    repeat (9) @(negedge clk);
    chk("pre_abort_bit_valid", {31'd0, bval[0]}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_ready", {29'd0, rdy}, 32'h7);
    chk("abort_outs", {20'd0, sout, bval, busy, fdone}, 32'd0);
    data_in    = 8'h96;
    data_valid = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("restart_first_sync", {30'd0, bval[0], sout[0]}, 32'h3);
    wait_idle("idle_after_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
